// File: rtl/uart_pkg.sv
// Shared constants and echo FSM state encoding for the UART echo path.
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        SEND_LF = 2'd2
    } echo_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy counter and synchronous flush.
// A push while full is accepted only when a pop happens on the same edge.
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic [LW-1:0]     level_d;
    logic              pop_ok_s;
    logic              push_ok_s;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == {LW{1'b0}});
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_ok_s);
    assign head_o    = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Occupancy follows the accepted push/pop pair, so it never wraps.
    always_comb begin
        level_d = level_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage array; contents are don't-care until written, so it has no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else if (clear_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffered UART echo: queues rx characters and replays them to the tx side.
// Build option UART_ECHO_CRLF_EN appends an LF after every transmitted CR.
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       rx_valid,
    input  logic [DATA_W-1:0]          rx_data,
    output logic                       tx_valid,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic [1:0]                 led
);

`ifdef UART_ECHO_CRLF_EN
    localparam logic [DATA_W-1:0] CR_W = DATA_W'(ASCII_CR);
    localparam logic [DATA_W-1:0] LF_W = DATA_W'(ASCII_LF);
`endif

    echo_state_e       state_q, state_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              overflow_q, overflow_d;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [DATA_W-1:0] fifo_head_s;

    assign fifo_push_s = rx_valid && !clear;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .push_i  (fifo_push_s),
        .data_i  (rx_data),
        .pop_i   (fifo_pop_s),
        .head_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (level)
    );

    // Echo FSM: loads the tx register from the FIFO head and pops on each completed handshake.
    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        fifo_pop_s = 1'b0;
        if (clear) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        fifo_pop_s = 1'b1;
                        tx_data_d  = fifo_head_s;
                        tx_valid_d = 1'b1;
                        state_d    = SEND;
                    end else begin
                        tx_valid_d = 1'b0;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
`ifdef UART_ECHO_CRLF_EN
                        if (tx_data_q == CR_W) begin
                            tx_data_d = LF_W;
                            state_d   = SEND_LF;
                        end else
`endif
                        if (!fifo_empty_s) begin
                            fifo_pop_s = 1'b1;
                            tx_data_d  = fifo_head_s;
                        end else begin
                            tx_valid_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end else begin
                        state_d = SEND;
                    end
                end
`ifdef UART_ECHO_CRLF_EN
                SEND_LF: begin
                    if (tx_ready) begin
                        if (!fifo_empty_s) begin
                            fifo_pop_s = 1'b1;
                            tx_data_d  = fifo_head_s;
                            state_d    = SEND;
                        end else begin
                            tx_valid_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end else begin
                        state_d = SEND_LF;
                    end
                end
`endif
                default: begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: set only when a write is refused (full with no pop on the same edge).
    always_comb begin
        overflow_d = overflow_q;
        if (clear) begin
            overflow_d = 1'b0;
        end else if (rx_valid && fifo_full_s && !fifo_pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State, tx output register and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= {DATA_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign led      = {overflow_q, (level != '0)};

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Scoreboard bench for uart_echo_buffer: a queue-based reference model predicts the tx stream,
// and an independent monitor checks every tx handshake against it.
module tb_uart_echo_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LW     = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic [LW-1:0]     level;
    logic              overflow;
    logic [1:0]        led;

    int n_checks = 0;
    int n_fail   = 0;
    int tx_count = 0;
    logic [7:0] sb [$];

    uart_echo_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .level    (level),
        .overflow (overflow),
        .led      (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: every accepted character is echoed once, in order; CR gains a trailing LF.
    function automatic void model_accept(input logic [7:0] c);
        sb.push_back(c);
`ifdef UART_ECHO_CRLF_EN
        if (c == 8'h0D) sb.push_back(8'h0A);
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] c, input bit accept);
        rx_data  = c;
        rx_valid = 1'b1;
        if (accept) model_accept(c);
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        tx_ready = 1'b1;
        for (int i = 0; i < 400 && sb.size() != 0; i++) cyc();
        cyc();
        chk(name, sb.size(), 32'd0);
        chk({name, "_idle"}, tx_valid, 32'd0);
    endtask

    // Monitor: every handshake must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
                tx_count++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got 0x%0h, expected no output", tx_data);
                end else begin
                    chk("tx_data", tx_data, sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pushed;
        int base;
        int n;
        rst_n = 1'b0; clear = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        repeat (3) cyc();
        chk("rst_level", level, 32'd0);
        chk("rst_tx_valid", tx_valid, 32'd0);
        chk("rst_tx_data", tx_data, 32'd0);
        chk("rst_overflow", overflow, 32'd0);
        chk("rst_led", led, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Single character: tx_valid rises two cycles after the rx strobe.
        tx_ready = 1'b1;
        push(8'h41, 1'b1);
        @(negedge clk);
        chk("lat_n1_valid", tx_valid, 32'd0);
        cyc();
        @(negedge clk);
        chk("lat_n2_valid", tx_valid, 32'd1);
        chk("lat_n2_data", tx_data, 32'h41);
        cyc(); cyc();
        chk("single_level", level, 32'd0);
        chk("single_led", led, 32'd0);
        chk("single_sb", sb.size(), 32'd0);

        // Burst with tx stalled: the first char sits in the tx register, so 17 writes fill the FIFO.
        tx_ready = 1'b0;
        for (int i = 0; i <= 16; i++) push(8'(i), 1'b1);
        chk("burst_level", level, 32'd16);
        chk("burst_no_ovf", overflow, 32'd0);
        push(8'h11, 1'b0);
        chk("burst_full_level", level, 32'd16);
        chk("burst_ovf", overflow, 32'd1);
        chk("burst_led", led, 32'd3);
        n = sb.size();
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("b2b_valid", tx_valid, 32'd1);
            cyc();
        end
        drain("burst_drain");
        chk("ovf_sticky", overflow, 32'd1);
        chk("ovf_led", led, 32'd2);

        // Clear with level 5, tx pending, overflow set and a same-cycle rx strobe.
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h50 + 8'(i), 1'b1);
        cyc();
        chk("pre_clr_level", level, 32'd5);
        chk("pre_clr_valid", tx_valid, 32'd1);
        clear = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
        cyc();
        clear = 1'b0; rx_valid = 1'b0;
        sb.delete();
        chk("clr_level", level, 32'd0);
        chk("clr_valid", tx_valid, 32'd0);
        chk("clr_ovf", overflow, 32'd0);
        chk("clr_led", led, 32'd0);
        cyc();
        chk("clr_discard_level", level, 32'd0);
        chk("clr_discard_valid", tx_valid, 32'd0);

        // Full FIFO with a write on the same cycle as a handshake pop.
        for (int i = 0; i <= 16; i++) push(8'h20 + 8'(i), 1'b1);
        chk("fs_level_pre", level, 32'd16);
        tx_ready = 1'b1;
        push(8'h31, 1'b1);
        tx_ready = 1'b0;
        chk("fs_level", level, 32'd16);
        chk("fs_ovf", overflow, 32'd0);
        drain("fs_drain");

        // Random stream with tx_ready toggling; stays below capacity so every write is accepted.
        pushed = 0;
        for (int c = 0; c < 2000 && pushed < 40; c++) begin
            tx_ready = ~tx_ready;
            if ($urandom_range(0, 1) == 1 && sb.size() < DEPTH) begin
                push(8'($urandom_range(0, 255)), 1'b1);
                pushed++;
            end else begin
                cyc();
            end
        end
        chk("wrap_pushed", pushed, 32'd40);
        drain("wrap_drain");
        chk("wrap_ovf", overflow, 32'd0);

        // CR handling.
        base = tx_count;
        tx_ready = 1'b1;
        push(8'h0D, 1'b1);
        push(8'h42, 1'b1);
        drain("crlf_drain");
`ifdef UART_ECHO_CRLF_EN
        chk("crlf_count", tx_count - base, 32'd3);
`else
        chk("crlf_count", tx_count - base, 32'd2);
`endif

        // Asynchronous reset in the middle of SEND.
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(8'h90 + 8'(i), 1'b1);
        cyc();
        chk("mid_valid", tx_valid, 32'd1);
        chk("mid_level", level, 32'd2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_valid", tx_valid, 32'd0);
        chk("arst_data", tx_data, 32'd0);
        chk("arst_level", level, 32'd0);
        chk("arst_ovf", overflow, 32'd0);
        chk("arst_led", led, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        chk("post_rst_valid", tx_valid, 32'd0);
        chk("final_sb", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
